div_ctrl: RTL and testbench



---
 rtl/div_ctrl_if.sv | 46 ++++
 rtl/div_ctrl.sv | 158 +++++++++++++++
 tb/tb_div_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Handshake bundle between the EXE stage, div_ctrl and the two divider cores.
// master is the controller's view; slave is the pipeline/core environment.
interface div_ctrl_if #(
    parameter int unsigned DW = 32
);
    // pipeline request / response
    logic              req_valid;
    logic [3:0]        req_op;
    logic [DW-1:0]     req_src1;
    logic [DW-1:0]     req_src2;
    logic              res_ack;
    logic              flush;
    logic              ready_go;
    logic [DW-1:0]     result;
    logic              busy;

    // operands shared by both cores
    logic [DW-1:0]     dividend;
    logic [DW-1:0]     divisor;

    // signed core stream
    logic              s_tvalid;
    logic              s_tready;
    logic              s_dout_tvalid;
    logic [2*DW-1:0]   s_dout;

    // unsigned core stream
    logic              u_tvalid;
    logic              u_tready;
    logic              u_dout_tvalid;
    logic [2*DW-1:0]   u_dout;

    modport master (
        input  req_valid, req_op, req_src1, req_src2, res_ack, flush,
        input  s_tready, s_dout_tvalid, s_dout,
        input  u_tready, u_dout_tvalid, u_dout,
        output ready_go, result, busy, dividend, divisor, s_tvalid, u_tvalid
    );

    modport slave (
        output req_valid, req_op, req_src1, req_src2, res_ack, flush,
        output s_tready, s_dout_tvalid, s_dout,
        output u_tready, u_dout_tvalid, u_dout,
        input  ready_go, result, busy, dividend, divisor, s_tvalid, u_tvalid
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequences one divide request at a time onto the signed or unsigned divider
// core, holds the selected quotient/remainder, and drains cores after a flush.
module div_ctrl #(
    parameter int unsigned DW = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            ready_go_q,    ready_go_nxt;
    logic            busy_q,        busy_nxt;
    logic            s_tvalid_q,    s_tvalid_nxt;
    logic            u_tvalid_q,    u_tvalid_nxt;
    logic [DW-1:0]   result_q,      result_nxt;
    logic [DW-1:0]   dividend_q,    dividend_nxt;
    logic [DW-1:0]   divisor_q,     divisor_nxt;
    logic            is_unsigned_q, is_unsigned_nxt;
    logic            want_rem_q,    want_rem_nxt;

    logic            accept;
    logic            src2_zero;
    logic            op_unsigned;
    logic            op_rem;
    logic            sel_tvalid;
    logic            sel_tready;
    logic            xfer;
    logic            sel_dout_valid;
    logic [2*DW-1:0] sel_dout;
    logic            unused_op_div;

    // op[0] (signed div) is implied by the other three bits being clear
    assign unused_op_div  = bus.req_op[0];

    assign accept         = (state == IDLE) && bus.req_valid && !bus.flush;
    assign src2_zero      = (bus.req_src2 == '0);
    assign op_unsigned    = bus.req_op[1] | bus.req_op[3];
    assign op_rem         = bus.req_op[2] | bus.req_op[3];

    // only the core picked at accept time is ever listened to
    assign sel_tvalid     = is_unsigned_q ? u_tvalid_q        : s_tvalid_q;
    assign sel_tready     = is_unsigned_q ? bus.u_tready      : bus.s_tready;
    assign sel_dout_valid = is_unsigned_q ? bus.u_dout_tvalid : bus.s_dout_tvalid;
    assign sel_dout       = is_unsigned_q ? bus.u_dout        : bus.s_dout;
    assign xfer           = (state == ISSUE) && sel_tvalid && sel_tready;

    // state and every registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ready_go_q    <= 1'b0;
            busy_q        <= 1'b0;
            s_tvalid_q    <= 1'b0;
            u_tvalid_q    <= 1'b0;
            result_q      <= '0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            is_unsigned_q <= 1'b0;
            want_rem_q    <= 1'b0;
        end else begin
            state         <= state_nxt;
            ready_go_q    <= ready_go_nxt;
            busy_q        <= busy_nxt;
            s_tvalid_q    <= s_tvalid_nxt;
            u_tvalid_q    <= u_tvalid_nxt;
            result_q      <= result_nxt;
            dividend_q    <= dividend_nxt;
            divisor_q     <= divisor_nxt;
            is_unsigned_q <= is_unsigned_nxt;
            want_rem_q    <= want_rem_nxt;
        end
    end

    // next-state; flush takes priority over completion wherever both can occur
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = src2_zero ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.flush) begin
                    state_nxt = xfer ? DRAIN : IDLE;
                end else if (xfer) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (sel_dout_valid) begin
                    state_nxt = bus.flush ? IDLE : DONE;
                end else if (bus.flush) begin
                    state_nxt = DRAIN;
                end
            end
            DONE: begin
                if (bus.flush || bus.res_ack) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (sel_dout_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // register inputs; handshake flags decode the next state so they are clean flops
    always_comb begin
        dividend_nxt    = dividend_q;
        divisor_nxt     = divisor_q;
        is_unsigned_nxt = is_unsigned_q;
        want_rem_nxt    = want_rem_q;
        result_nxt      = result_q;

        if (accept) begin
            dividend_nxt    = bus.req_src1;
            divisor_nxt     = bus.req_src2;
            is_unsigned_nxt = op_unsigned;
            want_rem_nxt    = op_rem;
            if (src2_zero) begin
                result_nxt = op_rem ? bus.req_src1 : '0;
            end
        end

        if ((state == WAIT) && sel_dout_valid && !bus.flush) begin
            result_nxt = want_rem_q ? sel_dout[DW-1:0] : sel_dout[2*DW-1:DW];
        end

        ready_go_nxt = (state_nxt == DONE);
        busy_nxt     = (state_nxt != IDLE);
        s_tvalid_nxt = (state_nxt == ISSUE) && !is_unsigned_nxt;
        u_tvalid_nxt = (state_nxt == ISSUE) &&  is_unsigned_nxt;
    end

    assign bus.ready_go = ready_go_q;
    assign bus.busy     = busy_q;
    assign bus.s_tvalid = s_tvalid_q;
    assign bus.u_tvalid = u_tvalid_q;
    assign bus.result   = result_q;
    assign bus.dividend = dividend_q;
    assign bus.divisor  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table for single requests, plus
// hand-written flush, backpressure, drain and reset sequences.
module tb_div_ctrl;

    localparam int unsigned DW      = 32;
    localparam int unsigned LAT     = 10;
    localparam int unsigned TIMEOUT = 200;

    localparam logic [3:0] OP_DIV  = 4'b0001;
    localparam logic [3:0] OP_DIVU = 4'b0010;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_MODU = 4'b1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_ctrl_if #(.DW(DW)) bus ();

    div_ctrl #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- divider core models ----------------
    logic s_ready_en = 1'b1;
    logic u_ready_en = 1'b1;
    assign bus.s_tready = s_ready_en;
    assign bus.u_tready = u_ready_en;

    int          s_cnt, u_cnt;
    logic [63:0] s_pend, u_pend;
    int          s_xfers = 0, u_xfers = 0;
    int          s_outs  = 0, u_outs  = 0;

    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {q, r};
    endfunction

    function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        return {a / b, a % b};
    endfunction

    // result appears LAT edges after the transfer edge, for one cycle
    always @(posedge clk) begin
        if (reset) begin
            s_cnt <= 0;
            bus.s_dout_tvalid <= 1'b0;
            bus.s_dout <= '0;
        end else begin
            bus.s_dout_tvalid <= 1'b0;
            if (bus.s_tvalid && bus.s_tready) begin
                s_cnt   <= LAT;
                s_pend  <= sdiv(bus.dividend, bus.divisor);
                s_xfers <= s_xfers + 1;
            end else if (s_cnt > 1) begin
                s_cnt <= s_cnt - 1;
            end else if (s_cnt == 1) begin
                s_cnt <= 0;
                bus.s_dout_tvalid <= 1'b1;
                bus.s_dout <= s_pend;
                s_outs <= s_outs + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            u_cnt <= 0;
            bus.u_dout_tvalid <= 1'b0;
            bus.u_dout <= '0;
        end else begin
            bus.u_dout_tvalid <= 1'b0;
            if (bus.u_tvalid && bus.u_tready) begin
                u_cnt   <= LAT;
                u_pend  <= udiv(bus.dividend, bus.divisor);
                u_xfers <= u_xfers + 1;
            end else if (u_cnt > 1) begin
                u_cnt <= u_cnt - 1;
            end else if (u_cnt == 1) begin
                u_cnt <= 0;
                bus.u_dout_tvalid <= 1'b1;
                bus.u_dout <= u_pend;
                u_outs <= u_outs + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
    endtask

    task automatic wait_ready(input string name, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (bus.ready_go !== 1'b1 && cyc < TIMEOUT);
        if (cyc >= TIMEOUT) chk({name, "_timeout"}, 64'(cyc), 64'(TIMEOUT - 1));
    endtask

    task automatic ack();
        bus.res_ack = 1'b1;
        step();
        bus.res_ack   = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          exp_lat;
        int          exp_s;
        int          exp_u;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int s0, u0, cyc;
        s0 = s_xfers;
        u0 = u_xfers;
        drive_req(v.op, v.a, v.b);
        wait_ready(v.name, cyc);
        chk({v.name, "_latency"}, 64'(cyc), 64'(v.exp_lat));
        chk({v.name, "_result"},  64'(bus.result), 64'(v.exp));
        chk({v.name, "_s_xfers"}, 64'(s_xfers - s0), 64'(v.exp_s));
        chk({v.name, "_u_xfers"}, 64'(u_xfers - u0), 64'(v.exp_u));
        ack();
        chk({v.name, "_busy_after_ack"}, 64'({bus.busy, bus.ready_go}), 64'd0);
    endtask

    vec_t vecs[11];

    initial begin
        int s0, u0, so0, cyc;
        logic saw_rg;

        vecs[0]  = '{"div_100_7",      OP_DIV,  32'd100,        32'd7,  32'd14,         LAT + 3, 1, 0};
        vecs[1]  = '{"modu_ffff_16",   OP_MODU, 32'hFFFF_FFFF,  32'd16, 32'h0000_000F,  LAT + 3, 0, 1};
        vecs[2]  = '{"mod_m7_2",       OP_MOD,  32'hFFFF_FFF9,  32'd2,  32'hFFFF_FFFF,  LAT + 3, 1, 0};
        vecs[3]  = '{"div_5_0",        OP_DIV,  32'd5,          32'd0,  32'd0,          1,       0, 0};
        vecs[4]  = '{"modu_5_0",       OP_MODU, 32'd5,          32'd0,  32'd5,          1,       0, 0};
        vecs[5]  = '{"divu_9_3",       OP_DIVU, 32'd9,          32'd3,  32'd3,          LAT + 3, 0, 1};
        vecs[6]  = '{"div_m100_7",     OP_DIV,  32'hFFFF_FF9C,  32'd7,  32'hFFFF_FFF2,  LAT + 3, 1, 0};
        vecs[7]  = '{"mod_100_7",      OP_MOD,  32'd100,        32'd7,  32'd2,          LAT + 3, 1, 0};
        vecs[8]  = '{"divu_ffff_2",    OP_DIVU, 32'hFFFF_FFFF,  32'd2,  32'h7FFF_FFFF,  LAT + 3, 0, 1};
        vecs[9]  = '{"mod_m7_0",       OP_MOD,  32'hFFFF_FFF9,  32'd0,  32'hFFFF_FFF9,  1,       0, 0};
        vecs[10] = '{"divu_m7_0",      OP_DIVU, 32'hFFFF_FFF9,  32'd0,  32'd0,          1,       0, 0};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.res_ack   = 1'b0;
        bus.flush     = 1'b0;
        step(); step(); step();

        chk("reset_flags",    64'({bus.ready_go, bus.busy, bus.s_tvalid, bus.u_tvalid}), 64'd0);
        chk("reset_result",   64'(bus.result),   64'd0);
        chk("reset_dividend", 64'(bus.dividend), 64'd0);
        chk("reset_divisor",  64'(bus.divisor),  64'd0);
        reset = 1'b0;
        step();

        // table of single requests, issued back to back
        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // flush 3 cycles after handshake, new divu request waits out the drain
        s0 = s_xfers; u0 = u_xfers; so0 = s_outs;
        drive_req(OP_DIV, 32'd100, 32'd7);
        step();                      // accept
        step();                      // transfer
        chk("fw_in_wait", 64'({bus.busy, bus.s_tvalid, bus.ready_go}), 64'b100);
        step(); step(); step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive_req(OP_DIVU, 32'd9, 32'd3);
        chk("fw_drain_flags", 64'({bus.busy, bus.ready_go}), 64'b10);
        saw_rg = 1'b0;
        cyc = 0;
        while (bus.u_tvalid !== 1'b1 && cyc < TIMEOUT) begin
            if (bus.ready_go === 1'b1) saw_rg = 1'b1;
            step();
            cyc++;
        end
        chk("fw_u_issue_timeout", 64'(cyc < TIMEOUT), 64'd1);
        chk("fw_no_ready_in_drain", 64'(saw_rg), 64'd0);
        chk("fw_stale_drained_first", 64'(s_outs - so0), 64'd1);
        wait_ready("fw_new", cyc);
        chk("fw_result", 64'(bus.result), 64'd3);
        chk("fw_s_xfers", 64'(s_xfers - s0), 64'd1);
        chk("fw_u_xfers", 64'(u_xfers - u0), 64'd1);
        ack();
        chk("fw_busy_after_ack", 64'(bus.busy), 64'd0);

        // backpressure: tvalid and operands stay put until tready
        s0 = s_xfers;
        s_ready_en = 1'b0;
        drive_req(OP_DIV, 32'd100, 32'd7);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_tvalid", 64'({bus.s_tvalid, bus.u_tvalid}), 64'b10);
            chk("bp_hold_ops", 64'({bus.dividend, bus.divisor}), {32'd100, 32'd7});
            step();
        end
        s_ready_en = 1'b1;
        step();
        chk("bp_xfer_once", 64'(s_xfers - s0), 64'd1);
        chk("bp_tvalid_drop", 64'(bus.s_tvalid), 64'd0);
        wait_ready("bp", cyc);
        chk("bp_result", 64'(bus.result), 64'd14);
        ack();

        // flush during the stall returns straight to IDLE, nothing reaches the core
        s0 = s_xfers;
        s_ready_en = 1'b0;
        drive_req(OP_DIV, 32'd100, 32'd7);
        step();
        step();
        bus.flush = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        chk("bpf_idle", 64'({bus.busy, bus.s_tvalid, bus.ready_go}), 64'd0);
        s_ready_en = 1'b1;
        step(); step();
        chk("bpf_no_xfer", 64'(s_xfers - s0), 64'd0);
        chk("bpf_still_idle", 64'(bus.busy), 64'd0);

        // flush together with res_ack in DONE
        drive_req(OP_MOD, 32'd100, 32'd7);
        wait_ready("fa", cyc);
        chk("fa_result", 64'(bus.result), 64'd2);
        bus.flush   = 1'b1;
        bus.res_ack = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.res_ack   = 1'b0;
        bus.req_valid = 1'b0;
        chk("fa_idle", 64'({bus.busy, bus.ready_go}), 64'd0);

        // flush in the same cycle the core answers: result must not be latched
        drive_req(OP_DIV, 32'd100, 32'd7);
        cyc = 0;
        while (bus.s_dout_tvalid !== 1'b1 && cyc < TIMEOUT) begin
            step();
            cyc++;
        end
        chk("fd_dout_timeout", 64'(cyc < TIMEOUT), 64'd1);
        bus.flush = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        chk("fd_idle", 64'({bus.busy, bus.ready_go}), 64'd0);
        chk("fd_result_kept", 64'(bus.result), 64'd2);
        step();
        chk("fd_stays_idle", 64'(bus.busy), 64'd0);

        // reset while the unsigned core is working
        drive_req(OP_DIVU, 32'd9, 32'd3);
        step(); step(); step();
        chk("rw_in_wait", 64'({bus.busy, bus.u_tvalid}), 64'b10);
        reset = 1'b1;
        bus.req_valid = 1'b0;
        step();
        chk("rw_flags",    64'({bus.ready_go, bus.busy, bus.s_tvalid, bus.u_tvalid}), 64'd0);
        chk("rw_result",   64'(bus.result),   64'd0);
        chk("rw_dividend", 64'(bus.dividend), 64'd0);
        chk("rw_divisor",  64'(bus.divisor),  64'd0);
        reset = 1'b0;
        step();

        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
